// File: rtl/mm_pkg.sv
// Shared definitions for the matrix tile loader: state encoding and default geometry.
package mm_pkg;

  localparam int MM_M  = 16;
  localparam int MM_N  = 16;
  localparam int MM_DW = 32;
  localparam int MM_CW = 16;
  localparam int MM_SW = MM_DW * MM_N;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/mm_row_buffer.sv
// M-slice register file holding one matrix tile; exposes all slices as a flat bus.
module mm_row_buffer
  import mm_pkg::*;
#(
  parameter int M  = MM_M,
  parameter int SW = MM_SW,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [SW-1:0]     wr_data,
  output logic [SW*M-1:0]   matrix
);

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_slice
      logic [SW-1:0] slice_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          slice_reg <= '0;
        end else if (wr_en && (wr_idx == IW'(gi))) begin
          slice_reg <= wr_data;
        end
      end

      assign matrix[gi*SW +: SW] = slice_reg;
    end
  endgenerate

endmodule

// File: rtl/mm_tile_loader.sv
// Tile loader: gathers M row slices, streams vectors, waits for all results.
// Optional MM_LOADER_STATS_EN adds stat_tiles / stat_stall counters.
module mm_tile_loader
  import mm_pkg::*;
#(
  parameter int M  = MM_M,
  parameter int N  = MM_N,
  parameter int DW = MM_DW,
  parameter int CW = MM_CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CW-1:0]        cmd_vec_cnt,
  input  logic [DW*N-1:0]      row_data,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [DW*N-1:0]      vec_data,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  output logic [DW*N*M-1:0]    matrix_input,
  output logic [DW*N-1:0]      vector_input,
  output logic                 input_valid,
  input  logic                 add_valid,
  output logic                 busy,
  output logic                 tile_done,
  output logic                 err_spurious
`ifdef MM_LOADER_STATS_EN
  ,
  output logic [31:0]          stat_tiles,
  output logic [31:0]          stat_stall
`endif
);

  localparam int SW = DW * N;
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  state_t          state_reg, state_next;
  logic [IW-1:0]   row_idx_reg;
  logic [CW-1:0]   cnt_reg, issued_reg, ret_reg;
  logic [SW-1:0]   vector_reg;
  logic            input_valid_reg;
  logic            err_reg;

  logic cmd_hs, row_hs, vec_hs, ret_ok;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign row_hs = row_valid & row_ready;
  assign vec_hs = vec_valid & vec_ready;
  // A result only counts while something is actually outstanding.
  assign ret_ok = add_valid && (ret_reg < issued_reg) &&
                  ((state_reg == ST_STREAM) || (state_reg == ST_DRAIN));

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    row_ready  = 1'b0;
    vec_ready  = 1'b0;
    tile_done  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        row_ready = 1'b1;
        if (row_valid && (row_idx_reg == IW'(M - 1)))
          state_next = (cnt_reg == '0) ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        vec_ready = (issued_reg < cnt_reg);
        if (issued_reg >= cnt_reg) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ret_reg == cnt_reg) begin
          tile_done  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      row_idx_reg     <= '0;
      cnt_reg         <= '0;
      issued_reg      <= '0;
      ret_reg         <= '0;
      vector_reg      <= '0;
      input_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      input_valid_reg <= vec_hs;
      if (cmd_hs) begin
        cnt_reg     <= cmd_vec_cnt;
        row_idx_reg <= '0;
        issued_reg  <= '0;
        ret_reg     <= '0;
      end
      if (row_hs) row_idx_reg <= row_idx_reg + IW'(1);
      if (vec_hs) begin
        vector_reg <= vec_data;
        issued_reg <= issued_reg + CW'(1);
      end
      if (ret_ok) ret_reg <= ret_reg + CW'(1);
      else if (add_valid) err_reg <= 1'b1;
    end
  end

  mm_row_buffer #(
    .M  (M),
    .SW (SW),
    .IW (IW)
  ) u_row_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (row_hs),
    .wr_idx  (row_idx_reg),
    .wr_data (row_data),
    .matrix  (matrix_input)
  );

  assign vector_input = vector_reg;
  assign input_valid  = input_valid_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign err_spurious = err_reg;

`ifdef MM_LOADER_STATS_EN
  logic [31:0] stat_tiles_reg, stat_stall_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_tiles_reg <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (tile_done) stat_tiles_reg <= stat_tiles_reg + 32'd1;
      if ((state_reg == ST_STREAM) && vec_ready && !vec_valid)
        stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_tiles = stat_tiles_reg;
  assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_mm_tile_loader.sv
// Scoreboard bench for mm_tile_loader: vectors queued at handshake, matched at input_valid.
module tb_mm_tile_loader;

  localparam int M  = 16;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SW = DW * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CW-1:0]     cmd_vec_cnt = '0;
  logic [SW-1:0]     row_data = '0;
  logic              row_valid = 1'b0;
  logic              row_ready;
  logic [SW-1:0]     vec_data = '0;
  logic              vec_valid = 1'b0;
  logic              vec_ready;
  logic [SW*M-1:0]   matrix_input;
  logic [SW-1:0]     vector_input;
  logic              input_valid;
  logic              add_valid;
  logic              busy;
  logic              tile_done;
  logic              err_spurious;
`ifdef MM_LOADER_STATS_EN
  logic [31:0]       stat_tiles;
  logic [31:0]       stat_stall;
`endif

  mm_tile_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_vec_cnt  (cmd_vec_cnt),
    .row_data     (row_data),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .vec_data     (vec_data),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .matrix_input (matrix_input),
    .vector_input (vector_input),
    .input_valid  (input_valid),
    .add_valid    (add_valid),
    .busy         (busy),
    .tile_done    (tile_done),
    .err_spurious (err_spurious)
`ifdef MM_LOADER_STATS_EN
    ,
    .stat_tiles   (stat_tiles),
    .stat_stall   (stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] obs_q[$];
  bit            lat_q[$];
  int            done_cnt = 0;
  int            iv_cnt = 0;
  int            missed = 0;
  logic          man_add = 1'b0;
  logic          resp_en = 1'b0;
  int            resp_lat = 4;
  logic [15:0]   pend = '0;
  logic          hs_pend = 1'b0;

  // Array model: returns add_valid resp_lat cycles after each input_valid.
  assign add_valid = pend[0] | man_add;

  always @(negedge clk) hs_pend <= vec_valid & vec_ready & rst_n;

  always @(posedge clk) begin
    #1;
    if (input_valid) begin
      obs_q.push_back(vector_input);
      lat_q.push_back(hs_pend);
      iv_cnt <= iv_cnt + 1;
    end else if (hs_pend) begin
      missed <= missed + 1;
    end
    if (tile_done) done_cnt <= done_cnt + 1;
    if (!rst_n) pend <= '0;
    else pend <= (pend >> 1) | ((input_valid && resp_en) ? (16'd1 << resp_lat) : 16'd0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [SW-1:0] pat(input int v);
    logic [DW-1:0] w;
    w = DW'(v);
    return {N{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int cnt);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_vec_cnt = CW'(cnt);
    while (!cmd_ready && k < 50) begin tick(); k++; end
    checks++;
    if (!cmd_ready) begin $display("FAIL cmd_timeout got=%0b want=1", cmd_ready); errors++; end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_row(input logic [SW-1:0] d);
    int k = 0;
    row_valid = 1'b1;
    row_data = d;
    while (!row_ready && k < 50) begin tick(); k++; end
    checks++;
    if (!row_ready) begin $display("FAIL row_timeout got=%0b want=1", row_ready); errors++; end
    tick();
    row_valid = 1'b0;
  endtask

  task automatic load_tile(input int base, input int step);
    for (int r = 0; r < M; r++) send_row(pat(base + r * step));
  endtask

  task automatic send_vec(input logic [SW-1:0] d, input int gap, input logic with_add);
    int k = 0;
    vec_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    vec_valid = 1'b1;
    vec_data = d;
    while (!vec_ready && k < 50) begin tick(); k++; end
    checks++;
    if (!vec_ready) begin $display("FAIL vec_timeout got=%0b want=1", vec_ready); errors++; end
    exp_q.push_back(d);
    man_add = with_add;
    tick();
    vec_valid = 1'b0;
    man_add = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!tile_done && k < 100) begin tick(); k++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || input_valid !== 1'b0 || tile_done !== 1'b0 || err_spurious !== 1'b0 ||
        row_ready !== 1'b0 || vec_ready !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL reset_ctrl got busy=%0b iv=%0b done=%0b err=%0b rr=%0b vr=%0b cr=%0b want 0000001",
               busy, input_valid, tile_done, err_spurious, row_ready, vec_ready, cmd_ready);
      errors++;
    end
    checks++;
    if (matrix_input !== '0 || vector_input !== '0) begin
      $display("FAIL reset_data got mat_lo=%h vec_lo=%h want 0", matrix_input[31:0], vector_input[31:0]);
      errors++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_tile();
    int d0, iv0, k;
    logic [SW-1:0] e, o;
    bit l;
    d0 = done_cnt; iv0 = iv_cnt;
    resp_en = 1'b1; resp_lat = 4;
    send_cmd(3);
    load_tile(0, 1);
    send_vec(pat(100), 0, 1'b0);
    send_vec(pat(101), 1, 1'b0);
    send_vec(pat(102), 0, 1'b0);
    wait_done(k);
    checks++;
    if (k != 5) begin $display("FAIL basic_done_latency got=%0d want=5", k); errors++; end
    for (int r = 0; r < M; r++) begin
      checks++;
      if (matrix_input[r*SW +: SW] !== pat(r)) begin
        $display("FAIL basic_slice%0d got=%h want=%h", r, matrix_input[r*SW +: 32], DW'(r)); errors++;
      end
    end
    tick(); tick();
    checks++;
    if (done_cnt - d0 != 1 || iv_cnt - iv0 != 3) begin
      $display("FAIL basic_counts got done=%0d iv=%0d want done=1 iv=3", done_cnt - d0, iv_cnt - iv0); errors++;
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL basic_idle got busy=%0b cr=%0b want 0 1", busy, cmd_ready); errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin $display("FAIL basic_vec_missing want=%h", e[31:0]); errors++; end
      else begin
        o = obs_q.pop_front(); l = lat_q.pop_front();
        if (o !== e || !l) begin $display("FAIL basic_vec got=%h lat=%0b want=%h lat=1", o[31:0], l, e[31:0]); errors++; end
      end
    end
  endtask

  task automatic test_zero_count();
    int d0, iv0;
    d0 = done_cnt; iv0 = iv_cnt;
    send_cmd(0);
    load_tile(7, 3);
    checks++;
    if (tile_done !== 1'b1) begin $display("FAIL zero_done got=%0b want=1", tile_done); errors++; end
    tick();
    checks++;
    if (busy !== 1'b0 || tile_done !== 1'b0) begin
      $display("FAIL zero_idle got busy=%0b done=%0b want 0 0", busy, tile_done); errors++;
    end
    tick();
    checks++;
    if (done_cnt - d0 != 1 || iv_cnt != iv0) begin
      $display("FAIL zero_counts got done=%0d iv=%0d want 1 0", done_cnt - d0, iv_cnt - iv0); errors++;
    end
    checks++;
    if (matrix_input[15*SW +: SW] !== pat(7 + 15 * 3)) begin
      $display("FAIL zero_slice15 got=%h want=%h", matrix_input[15*SW +: 32], DW'(52)); errors++;
    end
  endtask

  task automatic test_gapped_coincident();
    int d0, k;
    logic [SW-1:0] e, o;
    bit l;
    d0 = done_cnt;
    resp_en = 1'b0;
    send_cmd(4);
    load_tile(50, 2);
    send_vec(pat(200), 0, 1'b0);
    man_add = 1'b1; tick(); man_add = 1'b0;
    send_vec(pat(201), 2, 1'b0);
    checks++;
    if (cmd_ready !== 1'b0) begin $display("FAIL gap_cmd_ready got=%0b want=0", cmd_ready); errors++; end
    send_vec(pat(202), 0, 1'b1);
    send_vec(pat(203), 1, 1'b0);
    tick(); tick();
    checks++;
    if (tile_done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      $display("FAIL gap_drain got done=%0b busy=%0b cr=%0b want 0 1 0", tile_done, busy, cmd_ready); errors++;
    end
    man_add = 1'b1; tick(); tick(); man_add = 1'b0;
    wait_done(k);
    checks++;
    if (k != 0) begin $display("FAIL gap_done_latency got=%0d want=0", k); errors++; end
    repeat (3) tick();
    checks++;
    if (done_cnt - d0 != 1 || err_spurious !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL gap_final got done=%0d err=%0b cr=%0b want 1 0 1", done_cnt - d0, err_spurious, cmd_ready); errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin $display("FAIL gap_vec_missing want=%h", e[31:0]); errors++; end
      else begin
        o = obs_q.pop_front(); l = lat_q.pop_front();
        if (o !== e || !l) begin $display("FAIL gap_vec got=%h lat=%0b want=%h lat=1", o[31:0], l, e[31:0]); errors++; end
      end
    end
  endtask

  task automatic test_reset_mid_tile();
    int d0, k;
    logic [SW-1:0] e, o;
    bit l;
    resp_en = 1'b1;
    send_cmd(2);
    for (int r = 0; r < 8; r++) send_row(pat(900 + r));
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || matrix_input !== '0 || vector_input !== '0 || input_valid !== 1'b0 ||
        tile_done !== 1'b0 || row_ready !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL abort_state got busy=%0b mat_lo=%h vec_lo=%h iv=%0b done=%0b rr=%0b cr=%0b",
               busy, matrix_input[31:0], vector_input[31:0], input_valid, tile_done, row_ready, cmd_ready);
      errors++;
    end
    rst_n = 1'b1;
    tick();
    d0 = done_cnt;
    send_cmd(1);
    load_tile(9, 5);
    send_vec(pat(300), 0, 1'b0);
    wait_done(k);
    tick();
    checks++;
    if (k != 5 || done_cnt - d0 != 1) begin
      $display("FAIL reload_done got lat=%0d cnt=%0d want 5 1", k, done_cnt - d0); errors++;
    end
    for (int r = 0; r < M; r += 5) begin
      checks++;
      if (matrix_input[r*SW +: SW] !== pat(9 + r * 5)) begin
        $display("FAIL reload_slice%0d got=%h want=%h", r, matrix_input[r*SW +: 32], DW'(9 + r * 5)); errors++;
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin $display("FAIL reload_vec_missing want=%h", e[31:0]); errors++; end
      else begin
        o = obs_q.pop_front(); l = lat_q.pop_front();
        if (o !== e || !l) begin $display("FAIL reload_vec got=%h lat=%0b want=%h lat=1", o[31:0], l, e[31:0]); errors++; end
      end
    end
  endtask

  task automatic test_spurious();
    resp_en = 1'b0;
    checks++;
    if (err_spurious !== 1'b0) begin $display("FAIL spur_pre got=%0b want=0", err_spurious); errors++; end
    man_add = 1'b1; tick(); man_add = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL spur_set got err=%0b busy=%0b want 1 0", err_spurious, busy); errors++;
    end
    repeat (5) tick();
    checks++;
    if (err_spurious !== 1'b1) begin $display("FAIL spur_sticky got=%0b want=1", err_spurious); errors++; end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if (err_spurious !== 1'b0) begin $display("FAIL spur_clear got=%0b want=0", err_spurious); errors++; end
    tick();
  endtask

`ifdef MM_LOADER_STATS_EN
  task automatic test_stats();
    int k;
    logic [SW-1:0] e, o;
    bit l;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    checks++;
    if (stat_tiles !== 32'd0 || stat_stall !== 32'd0) begin
      $display("FAIL stats_reset got tiles=%0d stall=%0d want 0 0", stat_tiles, stat_stall); errors++;
    end
    resp_en = 1'b1;
    send_cmd(2);
    load_tile(1, 1);
    send_vec(pat(400), 0, 1'b0);
    send_vec(pat(401), 3, 1'b0);
    wait_done(k);
    tick();
    send_cmd(1);
    load_tile(2, 1);
    send_vec(pat(402), 2, 1'b0);
    wait_done(k);
    tick();
    checks++;
    if (stat_tiles !== 32'd2 || stat_stall !== 32'd5) begin
      $display("FAIL stats_count got tiles=%0d stall=%0d want 2 5", stat_tiles, stat_stall); errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin $display("FAIL stats_vec_missing want=%h", e[31:0]); errors++; end
      else begin
        o = obs_q.pop_front(); l = lat_q.pop_front();
        if (o !== e || !l) begin $display("FAIL stats_vec got=%h lat=%0b want=%h lat=1", o[31:0], l, e[31:0]); errors++; end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_tile();
    test_zero_count();
    test_gapped_coincident();
    test_reset_mid_tile();
    test_spurious();
`ifdef MM_LOADER_STATS_EN
    test_stats();
`endif
    checks++;
    if (obs_q.size() != 0 || missed != 0) begin
      $display("FAIL stray_outputs got extra=%0d missed=%0d want 0 0", obs_q.size(), missed); errors++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
